// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 4-digit multiplexed 7-segment scan controller:
//   SEG_BLANK     - all cathodes off (active-low, dp included)
//   AN_OFF        - all anodes off (active-low)
//   scan_state_e  - per-slot FSM states (anodes-off guard, then digit shown)
//   HEX_SEG_TABLE - active-low g..a patterns for hex nibbles 0..F
// No ports (package).
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Packed so that HEX_SEG_TABLE[n] is the pattern for nibble n; the
    // concatenation therefore lists F first and 0 last.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/seg_hex_decode.sv
// -----------------------------------------------------------------------------
// seg_hex_decode
// Purely combinational hex-nibble to 7-segment decoder (active-low g..a).
// Ports:
//   nib_i  [3:0]  hex nibble to display
//   seg_o  [6:0]  active-low cathodes, [6] = g ... [0] = a
// -----------------------------------------------------------------------------
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_TABLE[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. Each digit slot lasts REFRESH_DIV clocks: GUARD clocks with every
// anode off (prevents ghosting between digits), then the digit is shown for
// the rest of the slot. Inputs are sampled once per slot at the end of the
// guard phase and held for the whole show phase.
//
// Optional feature: define SEG_SCAN_BLINK_EN to add the blink_mask port and
// a frame counter that toggles a blink phase every BLINK_FRAMES frames; while
// the phase is 1, digits selected by blink_mask are kept dark.
//
// Parameters:
//   REFRESH_DIV   clocks per digit slot
//   GUARD         anodes-off clocks at the start of each slot (1..REFRESH_DIV-2)
//   BLINK_FRAMES  frames per blink phase (blink build only)
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   digits       [15:0] four hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_mask      [3:0] decimal point enable per digit
//   blank_mask   [3:0] keep digit dark
//   blink_mask   [3:0] blink digit (SEG_SCAN_BLINK_EN only)
//   seg          [7:0] active-low cathodes, [6:0] = g..a, [7] = dp (registered)
//   an           [3:0] active-low anodes, bit i = digit i (registered)
//   frame_start  one-cycle pulse on the first show cycle of digit 0 (registered)
// -----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GUARD        = 2,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blank_mask,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [3:0]  blink_mask,
`endif
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

    // Elaboration-time sanity check of the parameter set.
    if (GUARD < 1 || GUARD > REFRESH_DIV - 2 || BLINK_FRAMES < 1) begin : g_bad_params
        $error("seg_scan_ctrl: illegal REFRESH_DIV/GUARD/BLINK_FRAMES combination");
    end

    scan_state_e        state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         idx_q;
    logic [7:0]         seg_q;
    logic [3:0]         an_q;
    logic               frame_start_q;

    logic [3:0]         nib;
    logic [6:0]         seg7;
    logic               show_entry;
    logic               frame_start_d;
    logic               dark;
    logic [7:0]         show_seg_d;
    logic [3:0]         show_an_d;
    logic               blink_dark;

    assign nib = digits[{idx_q, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .nib_i (nib),
        .seg_o (seg7)
    );

    // Last guard cycle: this is where the digit's inputs are captured.
    assign show_entry    = (state_q == ST_GUARD) && (cnt_q == GUARD_LAST);
    assign frame_start_d = show_entry && (idx_q == 2'd0);

`ifdef SEG_SCAN_BLINK_EN
    localparam int unsigned BF_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

    logic [BF_W-1:0] blink_cnt_q;
    logic            blink_phase_q;

    // Frames are counted at their first show cycle; the phase used for a
    // slot is the one in effect when that slot's inputs are captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_start_d) begin
            if (blink_cnt_q == BF_LAST) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign blink_dark = blink_mask[idx_q] & blink_phase_q;
`else
    assign blink_dark = 1'b0;
`endif

    assign dark       = blank_mask[idx_q] | blink_dark;
    assign show_an_d  = dark ? AN_OFF    : ~(4'b0001 << idx_q);
    assign show_seg_d = dark ? SEG_BLANK : {~dp_mask[idx_q], seg7};

    // Slot sequencer. Outputs are loaded on entry to SHOW and held until the
    // slot ends, so input changes mid-slot cannot reach the pins. Returning
    // to GUARD forces the anodes off before idx moves on, so two anodes are
    // never low together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_GUARD;
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            seg_q         <= SEG_BLANK;
            an_q          <= AN_OFF;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            case (state_q)
                ST_GUARD: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (show_entry) begin
                        state_q       <= ST_SHOW;
                        seg_q         <= show_seg_d;
                        an_q          <= show_an_d;
                        frame_start_q <= frame_start_d;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_q <= ST_GUARD;
                        cnt_q   <= '0;
                        idx_q   <= idx_q + 1'b1;
                        seg_q   <= SEG_BLANK;
                        an_q    <= AN_OFF;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_GUARD;
                    cnt_q   <= '0;
                    seg_q   <= SEG_BLANK;
                    an_q    <= AN_OFF;
                end
            endcase
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    localparam int RD  = 8;
    localparam int GD  = 2;
    localparam int BF  = 2;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  blank_mask = 4'h0;
`ifdef SEG_SCAN_BLINK_EN
    logic [3:0]  blink_mask = 4'h0;
`endif
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    seg_scan_ctrl #(.REFRESH_DIV(RD), .GUARD(GD), .BLINK_FRAMES(BF)) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask  (blink_mask),
`endif
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Display patterns as listed for each hex value (dp bit off).
    logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: t = clocks since the last edge that saw rst high.
    // Slot s = t / RD, position in slot = t % RD, digit = s % 4.
    int   t = 0;
    int   cyc = 0;
    bit   armed = 0;
    int   last_fs = -1;

    logic [15:0] s_digits;
    logic [3:0]  s_dp, s_blank;
`ifdef SEG_SCAN_BLINK_EN
    logic [3:0]  s_blink;
`endif

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            t       <= 0;
            armed   <= 1'b1;
            last_fs <= -1;
        end else begin
            t <= t + 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            int s, pos, d;
            bit lit_dark, ph;
            logic [7:0] e_seg;
            logic [3:0] e_an;
            logic       e_fs;
            s   = t / RD;
            pos = t % RD;
            d   = s % 4;
            ph  = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
            // Frames begun before this slot's capture point.
            ph = ((((s + 3) / 4) / BF) % 2) == 1;
`endif
            if (pos < GD) begin
                e_seg = 8'hFF;
                e_an  = 4'hF;
                e_fs  = 1'b0;
            end else begin
                lit_dark = s_blank[d];
`ifdef SEG_SCAN_BLINK_EN
                lit_dark = lit_dark | (s_blink[d] & ph);
`endif
                if (lit_dark) begin
                    e_seg = 8'hFF;
                    e_an  = 4'hF;
                end else begin
                    e_seg = hex_tbl[s_digits[4*d +: 4]];
                    if (s_dp[d]) e_seg[7] = 1'b0;
                    e_an  = 4'hF;
                    e_an[d] = 1'b0;
                end
                e_fs = (pos == GD) && (d == 0);
            end
            chk("seg", {8'h00, seg}, {8'h00, e_seg});
            chk("an", {12'h000, an}, {12'h000, e_an});
            chk("frame_start", {15'h0, frame_start}, {15'h0, e_fs});
            chk("an_onehot", {15'h0, ($countones(~an) <= 1)}, 16'h0001);
            if (frame_start && !rst) begin
                if (last_fs >= 0) chk("fs_period", 16'(cyc - last_fs), 16'(FRAME));
                last_fs = cyc;
            end
            if (pos == GD - 1) begin
                s_digits = digits;
                s_dp     = dp_mask;
                s_blank  = blank_mask;
`ifdef SEG_SCAN_BLINK_EN
                s_blink  = blink_mask;
`endif
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pos(input int want, input string tag);
        for (int k = 0; k < 2 * FRAME && (t % FRAME) != want; k++) tick();
        chk(tag, 16'(t % FRAME), 16'(want));
    endtask

    initial begin
        // Reset with the basic pattern, then two full frames.
        rst = 1'b1;
        digits = 16'h1234;
        tick(3);
        rst = 1'b0;
        tick(2 * FRAME + 4);

        // Decimal point on digit 1 showing 'A'.
        digits  = 16'h00A0;
        dp_mask = 4'b0010;
        tick(2 * FRAME);

        // Digit 3 blanked.
        blank_mask = 4'b1000;
        tick(2 * FRAME);
        blank_mask = 4'b0000;
        dp_mask    = 4'b0000;

        // Change inputs during the show phase of digit 0.
        wait_pos(GD + 2, "wait_d0_show");
        digits  = 16'h5A7E;
        dp_mask = 4'b0001;
        tick(2 * FRAME);

        // Reset in the middle of digit 2's show phase.
        wait_pos(2 * RD + GD + 1, "wait_d2_show");
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(FRAME + 4);

`ifdef SEG_SCAN_BLINK_EN
        blink_mask = 4'b0001;
        digits     = 16'h9876;
        tick(8 * FRAME);
        blink_mask = 4'b0000;
`endif

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 4) digits     = 16'($urandom);
            if ($urandom_range(0, 99) < 3) dp_mask    = 4'($urandom);
            if ($urandom_range(0, 99) < 3) blank_mask = 4'($urandom);
`ifdef SEG_SCAN_BLINK_EN
            if ($urandom_range(0, 99) < 2) blink_mask = 4'($urandom);
`endif
            rst = ($urandom_range(0, 999) < 3);
            tick(1);
        end
        rst = 1'b0;
        tick(FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot (1 ms at 100 MHz).
REQ-002 SHALL have parameter GUARD, default 2, meaning the all-anodes-off cycles at the start of each slot; legal range 1 <= GUARD <= REFRESH_DIV-2.
REQ-003 SHALL have parameter BLINK_FRAMES, default 125, meaning full 4-digit frames per blink phase (used only with BLINK_EN).
REQ-004 Ports: clk  input  1  system clock, single clock domain; one clock; reset is synchronous and active-high.
REQ-005 Ports: rst  input  1  synchronous active-high reset.
REQ-006 Ports: digits  input  16  hex nibbles, [3:0] = digit 0 (rightmost) ... [15:12] = digit 3.
REQ-007 Ports: dp_mask  input  4  bit i = 1 lights the decimal point of digit i.
REQ-008 Ports: blank_mask  input  4  bit i = 1 keeps digit i dark.
REQ-009 Ports: blink_mask  input  4  bit i = 1 blinks digit i (present only with BLINK_EN).
REQ-010 Ports: seg  output  8  active-low cathodes, [6:0] = g..a, [7] = dp.
REQ-011 Ports: an  output  4  active-low anodes, bit i = digit i.
REQ-012 Ports: frame_start  output  1  one-cycle pulse when digit 0 enters SHOW.

Function
REQ-013 SHALL implement FSM {GUARD, SHOW}; each slot is GUARD state for GUARD cycles, then SHOW for REFRESH_DIV-GUARD cycles; slot period exactly REFRESH_DIV cycles.
REQ-014 In GUARD, an SHALL be 4'b1111 and seg 8'hFF.
REQ-015 SHALL advance the digit index 0->1->2->3->0 on the GUARD->SHOW... transition out of SHOW (end of slot), wrapping 3->0.
REQ-016 digits, dp_mask, blank_mask (and blink_mask) SHALL be sampled on the last GUARD cycle and held constant for the whole SHOW phase; changes mid-SHOW take effect next slot.
REQ-017 In SHOW, an SHALL have only bit idx low, unless the digit is blanked, in which case an = 4'b1111 and seg = 8'hFF.
REQ-018 seg[6:0] SHALL decode the nibble: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E (values with seg[7]=1).
REQ-019 seg[7] SHALL be 0 when dp_mask[idx] = 1 and the digit is not blanked, else 1.
REQ-020 seg, an, frame_start SHALL be registered outputs (no combinational path from inputs).
REQ-021 frame_start SHALL be 1 for exactly the first SHOW cycle of digit 0, once per 4*REFRESH_DIV cycles.
REQ-022 At most one anode SHALL be low in any cycle, including across slot boundaries.

Reset
REQ-023 While rst = 1 at a clk edge: state = GUARD, idx = 0, slot counter = 0, seg = 8'hFF, an = 4'b1111, frame_start = 0, blink phase = 0, blink frame counter = 0.
REQ-024 After rst deasserts, the first SHOW (digit 0, frame_start = 1) SHALL begin exactly GUARD cycles later; rst mid-slot aborts the slot immediately at the next edge.

Configuration
REQ-025 Macro SEG_SCAN_BLINK_EN: when defined, blink_mask port exists; a frame counter toggles blink phase after every BLINK_FRAMES frames (counted at frame_start); when phase = 1 a digit with blink_mask bit set is treated as blanked.
REQ-026 Without SEG_SCAN_BLINK_EN: no blink_mask port, no blink counter; behaviour otherwise identical.

Structure
REQ-027 Shared package seg_pkg SHALL hold SEG_BLANK (8'hFF), AN_OFF (4'b1111), the FSM state typedef and the 16-entry hex-to-segment table.
REQ-028 Hex decode SHALL be a combinational sub-module seg_hex_decode (4-bit in, 7-bit active-low out); all sequencing stays in seg_scan_ctrl.

Verification (REFRESH_DIV=8, GUARD=2, BLINK_FRAMES=2)
REQ-029 rst 3 cycles, digits=16'h1234, masks 0 -> 2 cycles an=1111, then an=1110 seg=8'h99 for 6 cycles with frame_start on first, then 1101/B0, 1011/A4, 0111/F9, repeat every 32 cycles.
REQ-030 digits=16'h00A0, dp_mask=4'b0010 -> digit 1 shows seg=8'h08, other digits C0 with seg[7]=1.
REQ-031 blank_mask=4'b1000 -> during digit 3 slot an=1111 seg=FF; frame_start period still 32 cycles.
REQ-032 Change digits mid-SHOW of digit 0 -> seg unchanged until the next slot; digit 0 shows new value only in the next frame.
REQ-033 Assert rst during SHOW of digit 2 -> next edge an=1111 seg=FF; digit 0 SHOW with frame_start exactly 2 cycles after rst release.
REQ-034 With SEG_SCAN_BLINK_EN, blink_mask=4'b0001 -> digit 0 lit for 2 frames, dark for 2 frames, alternating; other digits unaffected; assertion: never more than one anode low.
